// File: rtl/wb_io_pkg.sv
// Shared definitions for the Wishbone serializer: register map, STATUS layout,
// FSM state encoding and divider width.
package wb_io_pkg;

    localparam int DIV_W = 16;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_DIV    = 8'h04;
    localparam logic [7:0] REG_TXDATA = 8'h08;
    localparam logic [7:0] REG_STATUS = 8'h0C;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_LVL_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_e;

endpackage

// File: rtl/wb_io_serializer_if.sv
// Wishbone classic slave bus bundle used between a bus master and the serializer.
interface wb_io_serializer_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/wb_io_serializer_fifo.sv
// First-word-fall-through synchronous FIFO; pushes while full are dropped here
// and reported by the caller.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      level_d = level_q + LW'(1);
        else if (do_pop && !do_push) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/wb_io_serializer.sv
// Wishbone-programmable serializer: words written to TXDATA are queued and
// shifted out MSB first, each bit held for DIV+1 cycles.
module wb_io_serializer
    import wb_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_io_serializer_if.slave   wb,
    output logic                ser_data_o,
    output logic                ser_frame_o,
    output logic                ser_tick_o
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic             en_q, en_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ovf_q, ovf_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;

    logic             addr_hit, bus_req, wr_en, tx_push;
    logic [7:0]       offset;
    logic [31:0]      status, rdata;

    logic             fifo_pop, fifo_full, fifo_empty;
    logic [31:0]      fifo_rdata;
    logic [LW-1:0]    fifo_level;

    ser_state_e       state_q;
    logic [31:0]      shreg_q;
    logic [4:0]       bit_idx_q;
    logic [DIV_W-1:0] cnt_q;
    logic             ser_data_q, ser_frame_q, ser_tick_q;

    logic             unused_sel;

    assign unused_sel = ^wb.wbs_sel_i[3:2];
    assign offset     = wb.wbs_adr_i[7:0];
    assign addr_hit   = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign bus_req    = wb.wbs_cyc_i && wb.wbs_stb_i && addr_hit;
    assign wr_en      = bus_req && ack_q && wb.wbs_we_i;
    assign tx_push    = wr_en && (offset == REG_TXDATA);
    assign fifo_pop   = (state_q == ST_IDLE) && en_q && !fifo_empty;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (tx_push),
        .wdata (wb.wbs_dat_i),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        status                         = '0;
        status[STAT_EMPTY]             = fifo_empty;
        status[STAT_FULL]              = fifo_full;
        status[STAT_BUSY]              = (state_q != ST_IDLE);
        status[STAT_OVF]               = ovf_q;
        status[STAT_LVL_LSB +: 4]      = 4'(fifo_level);
        case (offset)
            REG_CTRL:   rdata = {31'b0, en_q};
            REG_DIV:    rdata = {{(32-DIV_W){1'b0}}, div_q};
            REG_STATUS: rdata = status;
            default:    rdata = '0;
        endcase
    end

    // Register writes land on the ack cycle; an overflow set beats a clear.
    always_comb begin
        en_d  = en_q;
        div_d = div_q;
        ovf_d = ovf_q;
        if (wr_en && offset == REG_CTRL && wb.wbs_sel_i[0]) en_d = wb.wbs_dat_i[0];
        if (wr_en && offset == REG_DIV) begin
            if (wb.wbs_sel_i[0]) div_d[7:0]  = wb.wbs_dat_i[7:0];
            if (wb.wbs_sel_i[1]) div_d[15:8] = wb.wbs_dat_i[15:8];
        end
        if (wr_en && offset == REG_STATUS && wb.wbs_dat_i[STAT_OVF]) ovf_d = 1'b0;
        if (tx_push && fifo_full) ovf_d = 1'b1;
        ack_d = bus_req && !ack_q;
        dat_d = ack_d ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            en_q  <= 1'b0;
            div_q <= '0;
            ovf_q <= 1'b0;
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            en_q  <= en_d;
            div_q <= div_d;
            ovf_q <= ovf_d;
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    // DIV is reloaded into the bit counter at every bit start.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            cnt_q       <= '0;
            ser_data_q  <= 1'b0;
            ser_frame_q <= 1'b0;
            ser_tick_q  <= 1'b0;
        end else begin
            ser_tick_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state_q     <= ST_SHIFT;
                        shreg_q     <= fifo_rdata;
                        bit_idx_q   <= 5'd31;
                        cnt_q       <= div_q;
                        ser_data_q  <= fifo_rdata[31];
                        ser_frame_q <= 1'b1;
                        ser_tick_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == '0) begin
                        if (bit_idx_q == 5'd0) begin
                            state_q     <= ST_GAP;
                            ser_frame_q <= 1'b0;
                            ser_data_q  <= 1'b0;
                        end else begin
                            bit_idx_q  <= bit_idx_q - 5'd1;
                            cnt_q      <= div_q;
                            shreg_q    <= {shreg_q[30:0], 1'b0};
                            ser_data_q <= shreg_q[30];
                            ser_tick_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                ST_GAP:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign ser_data_o   = ser_data_q;
    assign ser_frame_o  = ser_frame_q;
    assign ser_tick_o   = ser_tick_q;

endmodule

// File: doc/wb_io_serializer.md
WB_IO_SERIALIZER -- requirements
Module: wb_io_serializer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000: Wishbone base address; the block decodes wbs_adr_i[31:8] == BASE_ADDR[31:8].
REQ-002 Parameter DEPTH, default 8: TX FIFO depth in 32-bit words; must be a power of 2.
REQ-003 wb_clk_i  in  1: the single clock; all logic is on its rising edge.
REQ-004 wb_rst_i  in  1: synchronous, active-high reset.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each: Wishbone classic-cycle controls.
REQ-006 wbs_sel_i  in  4: byte lanes; honoured for CTRL and DIV writes only.
REQ-007 wbs_adr_i, wbs_dat_i  in  32 each: address and write data.
REQ-008 wbs_ack_o  out  1; wbs_dat_o  out  32: acknowledge and read data.
REQ-009 ser_data_o  out  1: serial bit, MSB first.
REQ-010 ser_frame_o  out  1: high for every cycle of a 32-bit word transmission.
REQ-011 ser_tick_o  out  1: one-cycle pulse on the first cycle of each bit.

Function
REQ-012 Register map (offset = adr[7:0]): 0x00 CTRL (bit0 EN), 0x04 DIV[15:0], 0x08 TXDATA (write-only, reads 0), 0x0C STATUS; other offsets read 0 and ignore writes.
REQ-013 STATUS: bit0 empty, bit1 full, bit2 busy (FSM not IDLE), bit3 overflow (sticky, cleared by a write of 1 to bit3), bits[7:4] FIFO level, all other bits 0.
REQ-014 Ack: wbs_ack_o rises the cycle after cyc&stb&address-match with ack low, lasts exactly 1 cycle; a held request is acked every other cycle; a non-matching address is never acked.
REQ-015 Writes and TXDATA pushes take effect on the ack cycle; wbs_dat_o is valid on the ack cycle and 0 otherwise.
REQ-016 A TXDATA write pushes all 32 bits regardless of wbs_sel_i.
REQ-017 A push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
REQ-018 FSM states IDLE, SHIFT, GAP; reset state IDLE.
REQ-019 IDLE -> SHIFT when EN=1 and FIFO non-empty: pop a word into the shift register, bit index 31, ser_frame_o=1, ser_tick_o=1.
REQ-020 SHIFT: each bit is held for DIV+1 cycles; DIV is sampled at each bit start, so a DIV change takes effect at the next bit.
REQ-021 After bit 0's period, SHIFT -> GAP: ser_frame_o=0, ser_data_o=0 for exactly 1 cycle; GAP -> IDLE.
REQ-022 Word latency: the first ser_tick_o occurs 1 cycle after IDLE sees EN=1 and non-empty; a word occupies 32*(DIV+1) frame cycles plus 1 gap cycle.
REQ-023 Clearing EN mid-word does not abort the word; it only blocks the IDLE -> SHIFT transition.
REQ-024 DIV=0: one bit per cycle, with ser_tick_o high on all 32 frame cycles.
REQ-025 The FIFO read and write pointers wrap modulo DEPTH; level ranges from 0 to DEPTH.

Reset
REQ-026 On wb_rst_i the block SHALL force: wbs_ack_o=0, wbs_dat_o=0, ser_data_o=0, ser_frame_o=0, ser_tick_o=0, EN=0, DIV=0, overflow=0, FIFO empty, FSM IDLE.
REQ-027 Reset asserted mid-word drops the word: ser_frame_o=0 the cycle after the reset edge, and FIFO contents are lost.

Structure
REQ-028 A shared package wb_io_pkg holds: the register offsets, the STATUS bit positions, the FSM state enum and the DIV width.
REQ-029 The FIFO is one sub-module, sync_fifo (parameter DEPTH, width 32), with push/pop/full/empty/level ports.

Verification
REQ-030 Reset, then read STATUS -> 0x0000_0001; read DIV -> 0; no ser_frame_o activity.
REQ-031 DIV=0, EN=1, write TXDATA 0xA5A5_0F0F -> 32-cycle frame, ser_data_o sequence 1,0,1,0,0,1,0,1,..., then a 1-cycle gap; STATUS bit0=1 afterwards.
REQ-032 DIV=3, EN=1, write 0x8000_0001 -> frame lasts 128 cycles; ser_data_o high for the first 4 cycles and the last 4 cycles; 32 ticks, spaced 4 cycles apart.
REQ-033 EN=0, push 9 words with DEPTH=8 -> STATUS=0x0000_008A (level 8, full, overflow); write 0x8 to STATUS -> overflow cleared; then EN=1 -> the first 8 words are sent in order.
REQ-034 Clear EN in the middle of word 1 of 2 queued words -> word 1 completes, word 2 is held, STATUS level=1.
REQ-035 Assert wb_rst_i at bit 10 of a frame -> ser_frame_o=0 the next cycle; STATUS=0x0000_0001; a read from address BASE_ADDR+0x100 is never acked.
